dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 115 +++++++++++
 tb/tb_dmem_responder.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// ============================================================================
// Module   : dmem_responder
// Brief    : Single-outstanding word memory responder with fixed response
//            latency, alignment/range error reporting and async-cleared array.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dmem_responder #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        ReqValid,
    input  logic        ReqWrite,
    input  logic [31:0] ReqAddr,
    input  logic [31:0] ReqWData,
    output logic        ReqReady,
    output logic        RespValid,
    input  logic        RespAck,
    output logic [31:0] RespRData,
    output logic        RespErr,
    output logic        Busy
);

    localparam int         AW         = $clog2(DEPTH);
    localparam logic [3:0] C_LAT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [3:0]    r_cnt;
    logic          r_write;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [31:0]   r_rdata;
    logic          r_err;
    logic [31:0]   r_mem [DEPTH];

    logic          w_accept;
    logic          w_finish;
    logic          w_addr_err;
    logic [AW-1:0] w_idx;

    assign w_accept   = ReqValid && (r_state == S_IDLE);
    assign w_finish   = (r_state == S_WAIT) && (r_cnt == 4'd0);
    // Anything above the array (upper address bits set) or not word-aligned.
    assign w_addr_err = (r_addr[1:0] != 2'b00) || (r_addr[31:AW+2] != '0);
    assign w_idx      = r_addr[AW+1:2];

    assign ReqReady  = (r_state == S_IDLE);
    assign RespValid = (r_state == S_RESP);
    assign Busy      = (r_state != S_IDLE);
    assign RespRData = r_rdata;
    assign RespErr   = r_err;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (ReqValid)     w_next = S_WAIT;
            S_WAIT:  if (r_cnt == 4'd0) w_next = S_RESP;
            S_RESP:  if (RespAck)      w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_write <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_cnt   <= C_LAT_INIT;
                r_write <= ReqWrite;
                r_addr  <= ReqAddr;
                r_wdata <= ReqWData;
            end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_finish) begin
                r_err   <= w_addr_err;
                r_rdata <= (w_addr_err || r_write) ? 32'd0 : r_mem[w_idx];
            end else if ((r_state == S_RESP) && RespAck) begin
                r_err   <= 1'b0;
                r_rdata <= 32'd0;
            end
        end
    end

    // Array is flop-based so reset can clear every word without a clock.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 32'd0;
            end
        end else if (w_finish && r_write && !w_addr_err) begin
            r_mem[w_idx] <= r_wdata;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ============================================================================
// Module   : tb_dmem_responder
// Brief    : Directed self-checking bench for dmem_responder (LATENCY 2, 1, 15).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_dmem_responder;

    logic        CLK;
    logic        RSTn;
    logic        ReqValid, ReqWrite, RespAck;
    logic [31:0] ReqAddr, ReqWData;
    logic        ReqReady, RespValid, RespErr, Busy;
    logic [31:0] RespRData;

    logic        lv, lw, lack;
    logic [31:0] la, ld;
    logic        rdy1, rv1, er1, busy1, rdy15, rv15, er15, busy15;
    logic [31:0] rd1, rd15;

    int checks   = 0;
    int failures = 0;

    dmem_responder #(.DEPTH(64), .LATENCY(2)) u_dut (
        .CLK(CLK), .RSTn(RSTn), .ReqValid(ReqValid), .ReqWrite(ReqWrite),
        .ReqAddr(ReqAddr), .ReqWData(ReqWData), .ReqReady(ReqReady),
        .RespValid(RespValid), .RespAck(RespAck), .RespRData(RespRData),
        .RespErr(RespErr), .Busy(Busy)
    );

    dmem_responder #(.DEPTH(64), .LATENCY(1)) u_lat1 (
        .CLK(CLK), .RSTn(RSTn), .ReqValid(lv), .ReqWrite(lw),
        .ReqAddr(la), .ReqWData(ld), .ReqReady(rdy1),
        .RespValid(rv1), .RespAck(lack), .RespRData(rd1),
        .RespErr(er1), .Busy(busy1)
    );

    dmem_responder #(.DEPTH(64), .LATENCY(15)) u_lat15 (
        .CLK(CLK), .RSTn(RSTn), .ReqValid(lv), .ReqWrite(lw),
        .ReqAddr(la), .ReqWData(ld), .ReqReady(rdy15),
        .RespValid(rv15), .RespAck(lack), .RespRData(rd15),
        .RespErr(er15), .Busy(busy15)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Presents one request, then counts cycles from the accepting edge until RespValid.
    task automatic do_req(input logic wr, input logic [31:0] a, input logic [31:0] d,
                          output int lat, output logic [31:0] rd, output logic er);
        int n;
        n = 0;
        while (!ReqReady && n < 40) begin
            @(posedge CLK); #1; n++;
        end
        ReqValid = 1'b1; ReqWrite = wr; ReqAddr = a; ReqWData = d;
        @(posedge CLK); #1;
        ReqValid = 1'b0; ReqWrite = ~wr; ReqAddr = 32'hFFFF_FFFF; ReqWData = 32'h0BAD_0BAD;
        lat = 0;
        while (!RespValid && lat < 40) begin
            @(posedge CLK); #1; lat++;
        end
        rd = RespRData;
        er = RespErr;
    endtask

    task automatic do_ack;
        RespAck = 1'b1;
        @(posedge CLK); #1;
        RespAck = 1'b0;
    endtask

    task automatic test_reset;
        RSTn = 1'b0; ReqValid = 1'b0; ReqWrite = 1'b0; ReqAddr = '0; ReqWData = '0; RespAck = 1'b0;
        lv = 1'b0; lw = 1'b0; la = '0; ld = '0; lack = 1'b0;
        #1;
        checks++;
        if ({ReqReady, RespValid, RespErr, Busy, RespRData} !== {1'b1, 1'b0, 1'b0, 1'b0, 32'd0}) begin
            failures++;
            $display("FAIL reset_outputs: rdy=%b rv=%b err=%b busy=%b rd=%h required 1 0 0 0 00000000",
                     ReqReady, RespValid, RespErr, Busy, RespRData);
        end
        @(posedge CLK); #1;
        RSTn = 1'b1;
    endtask

    task automatic test_store_load;
        int lat; logic [31:0] rd; logic er;
        do_req(1'b1, 32'h10, 32'hDEAD_BEEF, lat, rd, er);
        checks++;
        if (lat !== 2 || rd !== 32'd0 || er !== 1'b0) begin
            failures++;
            $display("FAIL store_resp: lat=%0d rd=%h err=%b required 2 00000000 0", lat, rd, er);
        end
        do_ack();
        checks++;
        if (ReqReady !== 1'b1 || RespValid !== 1'b0 || Busy !== 1'b0) begin
            failures++;
            $display("FAIL ack_to_idle: rdy=%b rv=%b busy=%b required 1 0 0", ReqReady, RespValid, Busy);
        end
        do_req(1'b0, 32'h10, 32'h0, lat, rd, er);
        checks++;
        if (lat !== 2 || rd !== 32'hDEAD_BEEF || er !== 1'b0) begin
            failures++;
            $display("FAIL load_after_store: lat=%0d rd=%h err=%b required 2 deadbeef 0", lat, rd, er);
        end
        do_ack();
        checks++;
        if (RespRData !== 32'd0 || RespErr !== 1'b0) begin
            failures++;
            $display("FAIL ack_clears: rd=%h err=%b required 00000000 0", RespRData, RespErr);
        end
    endtask

    task automatic test_errors;
        int lat; logic [31:0] rd; logic er;
        do_req(1'b1, 32'hFC, 32'hCAFE_F00D, lat, rd, er); do_ack();
        do_req(1'b0, 32'h13, 32'h0, lat, rd, er);
        checks++;
        if (er !== 1'b1 || rd !== 32'd0) begin
            failures++;
            $display("FAIL misaligned_load: err=%b rd=%h required 1 00000000", er, rd);
        end
        do_ack();
        do_req(1'b0, 32'h100, 32'h0, lat, rd, er);
        checks++;
        if (er !== 1'b1 || rd !== 32'd0) begin
            failures++;
            $display("FAIL range_load: err=%b rd=%h required 1 00000000", er, rd);
        end
        do_ack();
        do_req(1'b1, 32'h100, 32'h1111_1111, lat, rd, er); do_ack();
        do_req(1'b1, 32'h11, 32'h2222_2222, lat, rd, er);
        checks++;
        if (er !== 1'b1) begin
            failures++;
            $display("FAIL misaligned_store_err: err=%b required 1", er);
        end
        do_ack();
        do_req(1'b0, 32'hFC, 32'h0, lat, rd, er);
        checks++;
        if (er !== 1'b0 || rd !== 32'hCAFE_F00D) begin
            failures++;
            $display("FAIL top_word_kept: err=%b rd=%h required 0 cafef00d", er, rd);
        end
        do_ack();
        do_req(1'b0, 32'h00, 32'h0, lat, rd, er);
        checks++;
        if (rd !== 32'd0) begin
            failures++;
            $display("FAIL no_wrap_write: rd=%h required 00000000", rd);
        end
        do_ack();
        do_req(1'b0, 32'h10, 32'h0, lat, rd, er);
        checks++;
        if (rd !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL misaligned_no_write: rd=%h required deadbeef", rd);
        end
        do_ack();
    endtask

    task automatic test_hold;
        int lat; logic [31:0] rd; logic er;
        do_req(1'b0, 32'h10, 32'h0, lat, rd, er);
        for (int i = 0; i < 5; i++) begin
            ReqValid = 1'b1; ReqWrite = 1'b1; ReqAddr = 32'h10; ReqWData = 32'h5555_0000 + i;
            @(posedge CLK); #1;
            checks++;
            if (RespValid !== 1'b1 || RespRData !== 32'hDEAD_BEEF || RespErr !== 1'b0 || ReqReady !== 1'b0) begin
                failures++;
                $display("FAIL hold_stable[%0d]: rv=%b rd=%h err=%b rdy=%b required 1 deadbeef 0 0",
                         i, RespValid, RespRData, RespErr, ReqReady);
            end
        end
        ReqValid = 1'b0;
        do_ack();
        checks++;
        if (ReqReady !== 1'b1 || RespValid !== 1'b0) begin
            failures++;
            $display("FAIL hold_release: rdy=%b rv=%b required 1 0", ReqReady, RespValid);
        end
        // Ack held high from acceptance through WAIT must not shortcut the transaction.
        RespAck = 1'b1; ReqValid = 1'b1; ReqWrite = 1'b0; ReqAddr = 32'h10;
        @(posedge CLK); #1;
        ReqValid = 1'b0;
        @(posedge CLK); #1;
        RespAck = 1'b0;
        @(posedge CLK); #1;
        checks++;
        if (RespValid !== 1'b1 || RespRData !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL ack_ignored_in_wait: rv=%b rd=%h required 1 deadbeef", RespValid, RespRData);
        end
        do_ack();
    endtask

    task automatic test_back_to_back;
        int lat; logic [31:0] rd; logic er;
        do_req(1'b1, 32'h3C, 32'hA5A5_A5A5, lat, rd, er);
        do_ack();
        do_req(1'b0, 32'h3C, 32'h0, lat, rd, er);
        checks++;
        if (lat !== 2 || rd !== 32'hA5A5_A5A5 || er !== 1'b0) begin
            failures++;
            $display("FAIL back_to_back: lat=%0d rd=%h err=%b required 2 a5a5a5a5 0", lat, rd, er);
        end
        do_ack();
    endtask

    task automatic test_reset_abort;
        int lat; logic [31:0] rd; logic er;
        do_req(1'b0, 32'h3C, 32'h0, lat, rd, er);
        #2 RSTn = 1'b0;
        #1;
        checks++;
        if (RespValid !== 1'b0 || RespRData !== 32'd0 || Busy !== 1'b0 || ReqReady !== 1'b1) begin
            failures++;
            $display("FAIL async_reset_resp: rv=%b rd=%h busy=%b rdy=%b required 0 00000000 0 1",
                     RespValid, RespRData, Busy, ReqReady);
        end
        #1 RSTn = 1'b1;
        do_req(1'b0, 32'h3C, 32'h0, lat, rd, er);
        checks++;
        if (lat !== 2 || rd !== 32'd0) begin
            failures++;
            $display("FAIL post_reset_accept: lat=%0d rd=%h required 2 00000000", lat, rd);
        end
        do_ack();
        ReqValid = 1'b1; ReqWrite = 1'b1; ReqAddr = 32'h04; ReqWData = 32'h1234_5678;
        @(posedge CLK); #1;
        ReqValid = 1'b0;
        @(posedge CLK); #1;
        RSTn = 1'b0;
        #1;
        checks++;
        if (Busy !== 1'b0 || ReqReady !== 1'b1 || RespValid !== 1'b0) begin
            failures++;
            $display("FAIL async_reset_wait: busy=%b rdy=%b rv=%b required 0 1 0", Busy, ReqReady, RespValid);
        end
        #2 RSTn = 1'b1;
        do_req(1'b0, 32'h04, 32'h0, lat, rd, er);
        checks++;
        if (rd !== 32'd0 || er !== 1'b0) begin
            failures++;
            $display("FAIL aborted_store: rd=%h err=%b required 00000000 0", rd, er);
        end
        do_ack();
    endtask

    task automatic test_latency;
        int c1, c15;
        c1 = -1; c15 = -1;
        lv = 1'b1; lw = 1'b0; la = 32'h20;
        @(posedge CLK); #1;
        lv = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge CLK); #1;
            if (rv1 && c1 < 0)   c1 = n;
            if (rv15 && c15 < 0) c15 = n;
            if (c1 >= 0 && c15 >= 0) break;
        end
        checks++;
        if (c1 !== 1) begin
            failures++;
            $display("FAIL latency1: cycles=%0d required 1", c1);
        end
        checks++;
        if (c15 !== 15 || rd15 !== 32'd0 || er15 !== 1'b0) begin
            failures++;
            $display("FAIL latency15: cycles=%0d rd=%h err=%b required 15 00000000 0", c15, rd15, er15);
        end
        lack = 1'b1;
        @(posedge CLK); #1;
        lack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_errors();
        test_hold();
        test_back_to_back();
        test_latency();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
